// File: rtl/systolic_tile_feeder.sv
// rtl/systolic_tile_feeder.sv - stream front end that loads, runs and drains the 3x3 systolic array
module systolic_tile_feeder #(
  parameter int DATA_W     = 8,
  parameter int RST_CYCLES = 3,
  parameter int RUN_CYCLES = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                arr_rst,
  output logic [16*DATA_W-1:0] i_bus,
  output logic [9*DATA_W-1:0]  f_bus,
  input  logic [4*DATA_W-1:0]  o_bus
);

  localparam int MAX_CYC = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {LOAD, RST_HOLD, RUN, CAPTURE, DRAIN} state_t;

  state_t                state, state_nx;
  logic [4:0]            cnt;
  logic [TW-1:0]         tmr;
  logic [1:0]            didx;
  logic [4*DATA_W-1:0]   result;
  logic [DATA_W-1:0]     slot_q [25];

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:     if (in_valid && cnt == 5'd24) state_nx = RST_HOLD;
      RST_HOLD: if (tmr == TW'(RST_CYCLES - 1)) state_nx = RUN;
      RUN:      if (tmr == TW'(RUN_CYCLES - 1)) state_nx = CAPTURE;
      CAPTURE:  state_nx = DRAIN;
      DRAIN:    if (out_ready && didx == 2'd3) state_nx = LOAD;
      default:  state_nx = LOAD;
    endcase
  end

  // Array is held in reset everywhere except RUN, so it restarts cleanly for each tile.
  always_comb begin
    in_ready  = (state == LOAD) && !rst;
    busy      = (state != LOAD);
    arr_rst   = (state != RUN);
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && (didx == 2'd3);
    out_data  = '0;
    if (state == DRAIN) begin
      case (didx)
        2'd0:    out_data = result[4*DATA_W-1:3*DATA_W];
        2'd1:    out_data = result[3*DATA_W-1:2*DATA_W];
        2'd2:    out_data = result[2*DATA_W-1:DATA_W];
        default: out_data = result[DATA_W-1:0];
      endcase
    end
  end

  // Phase timer restarts on every state change and counts only in the timed phases.
  always_ff @(posedge clk) begin
    if (rst || state_nx != state) tmr <= '0;
    else if (state == RST_HOLD || state == RUN) tmr <= tmr + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      didx   <= '0;
      result <= '0;
      for (int k = 0; k < 25; k++) slot_q[k] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            slot_q[cnt] <= in_data;
            cnt         <= (cnt == 5'd24) ? 5'd0 : cnt + 5'd1;
          end
        end
        CAPTURE: begin
          result <= o_bus;
          didx   <= '0;
        end
        DRAIN: begin
          if (out_ready) begin
            didx <= didx + 2'd1;
            if (didx == 2'd3) cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    i_bus = '0;
    f_bus = '0;
    for (int k = 0; k < 16; k++) i_bus[(16-k)*DATA_W-1 -: DATA_W] = slot_q[k];
    for (int k = 0; k < 9; k++)  f_bus[(9-k)*DATA_W-1 -: DATA_W]  = slot_q[16+k];
  end

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// tb/tb_systolic_tile_feeder.sv - randomized self-checking bench for systolic_tile_feeder
module tb_systolic_tile_feeder;

  localparam int RST_C = 3;
  localparam int RUN_C = 50;

  logic         clk = 0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;
  logic         arr_rst;
  logic [127:0] i_bus;
  logic [71:0]  f_bus;
  logic [31:0]  o_bus;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]   tile_b [25];
  logic [127:0] exp_i;
  logic [71:0]  exp_f;

  systolic_tile_feeder #(.DATA_W(8), .RST_CYCLES(RST_C), .RUN_CYCLES(RUN_C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .arr_rst(arr_rst), .i_bus(i_bus), .f_bus(f_bus), .o_bus(o_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic random_tile();
    for (int k = 0; k < 25; k++) tile_b[k] = 8'($urandom);
  endtask

  task automatic model_buses();
    exp_i = '0;
    exp_f = '0;
    for (int k = 0; k < 16; k++) exp_i = {exp_i[119:0], tile_b[k]};
    for (int k = 16; k < 25; k++) exp_f = {exp_f[63:0], tile_b[k]};
  endtask

  task automatic load_tile(input int nbytes, input bit gaps);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (n < nbytes && guard < 400) begin
      @(negedge clk);
      guard++;
      in_valid = gaps ? guard[0] : 1'b1;
      in_data  = in_valid ? tile_b[n] : 8'($urandom);
      if (in_valid && in_ready) n++;
    end
    tests_run++;
    if (n !== nbytes) begin
      tests_failed++;
      $display("FAIL load_count: accepted %0d bytes, required %0d", n, nbytes);
    end
  endtask

  task automatic run_tile(input bit gaps, input logic [31:0] oval, input int stall, input bit poke, input string tag);
    int hi;
    int lo;
    logic [7:0] eb;
    o_bus = oval;
    model_buses();
    load_tile(25, gaps);
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (i_bus !== exp_i || f_bus !== exp_f) begin
      tests_failed++;
      $display("FAIL %s buses_T1: i_bus=%h f_bus=%h, required %h %h", tag, i_bus, f_bus, exp_i, exp_f);
    end
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy_T1: busy=%b in_ready=%b, required 1 0", tag, busy, in_ready);
    end
    hi = 0;
    while (arr_rst === 1'b1 && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    tests_run++;
    if (hi !== RST_C) begin
      tests_failed++;
      $display("FAIL %s rst_hold_len: %0d cycles, required %0d", tag, hi, RST_C);
    end
    lo = 0;
    while (arr_rst === 1'b0 && lo < 200) begin
      lo++;
      if (poke) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++;
    if (lo !== RUN_C) begin
      tests_failed++;
      $display("FAIL %s run_len: %0d cycles, required %0d", tag, lo, RUN_C);
    end
    tests_run++;
    if (out_valid !== 1'b0 || i_bus !== exp_i || f_bus !== exp_f) begin
      tests_failed++;
      $display("FAIL %s capture_cycle: out_valid=%b i_bus=%h f_bus=%h, required 0 %h %h", tag, out_valid, i_bus, f_bus, exp_i, exp_f);
    end
    for (int j = 0; j < 4; j++) begin
      eb = 8'(oval >> (8 * (3 - j)));
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        out_ready = (s == stall);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== eb || out_last !== (j == 3)) begin
          tests_failed++;
          $display("FAIL %s drain_b%0d_s%0d: valid=%b data=%h last=%b, required 1 %h %b", tag, j, s, out_valid, out_data, out_last, eb, (j == 3));
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after_drain: in_ready=%b out_valid=%b busy=%b, required 1 0 0", tag, in_ready, out_valid, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || arr_rst !== 1'b1 || out_valid !== 1'b0 ||
        out_data !== 8'h00 || out_last !== 1'b0 || i_bus !== '0 || f_bus !== '0) begin
      tests_failed++;
      $display("FAIL %s: in_ready=%b busy=%b arr_rst=%b out_valid=%b out_data=%h out_last=%b i_bus=%h f_bus=%h, required 0 0 1 0 00 0 0 0",
               tag, in_ready, busy, arr_rst, out_valid, out_data, out_last, i_bus, f_bus);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || arr_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b arr_rst=%b, required 1 1", in_ready, arr_rst);
    end
  endtask

  task automatic test_basic();
    tile_b = '{8'd8, 8'd3, 8'd9, 8'd1, 8'd7, 8'd7, 8'd2, 8'd8, 8'd5, 8'd6, 8'd3, 8'd1, 8'd4,
               8'd9, 8'd2, 8'd6, 8'd1, 8'd5, 8'd8, 8'd6, 8'd0, 8'd7, 8'd3, 8'd1, 8'd2};
    run_tile(1'b0, 32'hA1B2C3D4, 0, 1'b0, "basic");
    tests_run++;
    if (i_bus !== 128'h08030901_07070208_05060301_04090206 || f_bus !== 72'h010508060007030102) begin
      tests_failed++;
      $display("FAIL basic_literal_buses: i_bus=%h f_bus=%h", i_bus, f_bus);
    end
  endtask

  task automatic test_backpressure();
    random_tile();
    run_tile(1'b0, $urandom, 5, 1'b0, "backpressure");
  endtask

  task automatic test_load_gaps();
    random_tile();
    run_tile(1'b1, $urandom, 0, 1'b0, "load_gaps");
    random_tile();
    run_tile(1'b0, $urandom, 1, 1'b1, "run_poke");
  endtask

  task automatic test_reset_mid();
    random_tile();
    load_tile(10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_load");
    rst = 1'b0;
    random_tile();
    run_tile(1'b0, $urandom, 0, 1'b0, "reload_after_load_rst");
    random_tile();
    load_tile(25, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int g = 0; g < 20 && arr_rst === 1'b1; g++) @(negedge clk);
    repeat (7) @(negedge clk);
    tests_run++;
    if (arr_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL reach_run: arr_rst=%b, required 0", arr_rst);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_run");
    rst = 1'b0;
    random_tile();
    run_tile(1'b0, $urandom, 0, 1'b0, "reload_after_run_rst");
  endtask

  task automatic test_back_to_back();
    random_tile();
    run_tile(1'b0, 32'h01020304, 0, 1'b0, "b2b_first");
    random_tile();
    run_tile(1'b0, 32'hFFEEDDCC, 0, 1'b0, "b2b_second");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    o_bus     = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_load_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
